sdm_dac: RTL and testbench



---
 rtl/sdm_dac_pkg.sv | 13 +
 rtl/sync_fifo.sv | 52 +++++
 rtl/sdm_dac.sv | 121 ++++++++++++
 tb/tb_sdm_dac.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/sdm_dac_pkg.sv
// Shared types and helpers for the sigma-delta DAC modulator.
package sdm_dac_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic int cnt_width(input int osr);
    return $clog2(osr);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO; pointers carry one extra wrap bit so full and empty
// can be told apart without a separate occupancy counter.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  assign wr_d = do_push ? wr_q + (AW + 1)'(1) : wr_q;
  assign rd_d = do_pop  ? rd_q + (AW + 1)'(1) : rd_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_q[AW-1:0]] <= data_i;
    end
  end

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign head_o  = mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/sdm_dac.sv
// First-order sigma-delta DAC: buffered sample codes become OSR-cycle windows
// of pulse-density output on bit_o.
module sdm_dac
  import sdm_dac_pkg::*;
#(
  parameter int RESOLUTION = 8,
  parameter int OSR        = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  enable_i,
  input  logic [RESOLUTION-1:0] data_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic                  bit_o,
  output logic                  busy_o,
  output logic                  underrun_o
);

  localparam int CW = cnt_width(OSR);
  localparam logic [CW-1:0] CntMax = CW'(OSR - 1);

  state_t                  state_q, state_d;
  logic [RESOLUTION-1:0]   acc_q, acc_d;
  logic [RESOLUTION-1:0]   cur_q, cur_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    bit_q, bit_d;
  logic                    underrun_q, underrun_d;
  logic                    pop;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [RESOLUTION-1:0]   fifo_head;
  logic [RESOLUTION:0]     sum;

  sync_fifo #(
    .WIDTH (RESOLUTION),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (valid_i),
    .pop_i   (pop),
    .data_i  (data_i),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // The carry out of the accumulator is the modulated bit.
  assign sum = {1'b0, acc_q} + {1'b0, cur_q};

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cur_d      = cur_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    underrun_d = 1'b0;
    pop        = 1'b0;
    case (state_q)
      IDLE: begin
        acc_d = '0;
        bit_d = 1'b0;
        if (enable_i && !fifo_empty) begin
          pop     = 1'b1;
          cur_d   = fifo_head;
          cnt_d   = CntMax;
          state_d = RUN;
        end
      end
      RUN: begin
        if (!enable_i) begin
          state_d = IDLE;
          acc_d   = '0;
          bit_d   = 1'b0;
        end else begin
          acc_d = sum[RESOLUTION-1:0];
          bit_d = sum[RESOLUTION];
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
            // Sample boundary: an empty FIFO replays the held sample.
            cnt_d = CntMax;
            if (!fifo_empty) begin
              pop   = 1'b1;
              cur_d = fifo_head;
            end else begin
              underrun_d = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      cur_q      <= '0;
      cnt_q      <= '0;
      bit_q      <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cur_q      <= cur_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      underrun_q <= underrun_d;
    end
  end

  assign ready_o    = !fifo_full;
  assign bit_o      = bit_q;
  assign busy_o     = (state_q == RUN);
  assign underrun_o = underrun_q;

endmodule

// File: tb/tb_sdm_dac.sv
// Directed bench for sdm_dac: table-driven single-sample windows plus
// hand-written multi-cycle sequences.
module tb_sdm_dac;

  logic       clk_i;
  logic       rst_ni;
  logic       enable_i;
  logic [7:0] data_i;
  logic       valid_i;
  logic       ready_o;
  logic       bit_o;
  logic       busy_o;
  logic       underrun_o;

  int vectors;
  int miscompares;

  typedef struct {
    logic [7:0] code;
    int         expOnes;
    logic [3:0] expFirst;
  } vec_t;

  vec_t vecs[7];

  sdm_dac #(
    .RESOLUTION (8),
    .OSR        (32),
    .FIFO_DEPTH (2)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .enable_i   (enable_i),
    .data_i     (data_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .bit_o      (bit_o),
    .busy_o     (busy_o),
    .underrun_o (underrun_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic pushSample(input logic [7:0] code);
    data_i  = code;
    valid_i = 1'b1;
    step();
    valid_i = 1'b0;
  endtask

  task automatic applyStimulus(input int n, output int ones, output logic [3:0] first,
                               output int pulses);
    ones   = 0;
    pulses = 0;
    first  = '0;
    for (int i = 0; i < n; i++) begin
      step();
      if (bit_o) ones++;
      if (i < 4) first[3-i] = bit_o;
      if (underrun_o) pulses++;
    end
  endtask

  int         ones;
  int         pulses;
  logic [3:0] first;

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_ni      = 1'b0;
    enable_i    = 1'b0;
    data_i      = '0;
    valid_i     = 1'b0;

    vecs[0] = '{8'h80, 16, 4'b0101};
    vecs[1] = '{8'h40,  8, 4'b0001};
    vecs[2] = '{8'hFF, 31, 4'b0111};
    vecs[3] = '{8'h00,  0, 4'b0000};
    vecs[4] = '{8'hC0, 24, 4'b0111};
    vecs[5] = '{8'h01,  0, 4'b0000};
    vecs[6] = '{8'h33,  6, 4'b0000};

    #12;
    checkOutput("reset ready", int'(ready_o), 1);
    checkOutput("reset busy", int'(busy_o), 0);
    checkOutput("reset bit", int'(bit_o), 0);
    checkOutput("reset underrun", int'(underrun_o), 0);
    rst_ni = 1'b1;
    step();

    // Single-sample windows from a cleared accumulator.
    for (int v = 0; v < 7; v++) begin
      pushSample(vecs[v].code);
      enable_i = 1'b1;
      step();
      checkOutput($sformatf("vec%0d busy start", v), int'(busy_o), 1);
      applyStimulus(32, ones, first, pulses);
      checkOutput($sformatf("vec%0d ones", v), ones, vecs[v].expOnes);
      checkOutput($sformatf("vec%0d first4", v), int'(first), int'(vecs[v].expFirst));
      checkOutput($sformatf("vec%0d underrun", v), pulses, 1);
      enable_i = 1'b0;
      step();
      checkOutput($sformatf("vec%0d busy end", v), int'(busy_o), 0);
      checkOutput($sformatf("vec%0d bit end", v), int'(bit_o), 0);
    end

    // Backpressure: third back-to-back push is refused.
    data_i  = 8'h11;
    valid_i = 1'b1;
    step();
    checkOutput("bp ready after 1", int'(ready_o), 1);
    data_i = 8'h22;
    step();
    checkOutput("bp ready after 2", int'(ready_o), 0);
    data_i = 8'h33;
    step();
    checkOutput("bp ready after 3", int'(ready_o), 0);
    checkOutput("bp bit idle", int'(bit_o), 0);
    valid_i  = 1'b0;
    enable_i = 1'b1;
    step();
    checkOutput("bp ready after pop", int'(ready_o), 1);
    applyStimulus(32, ones, first, pulses);
    checkOutput("bp 0x11 ones", ones, 2);
    checkOutput("bp 0x11 underrun", pulses, 0);
    applyStimulus(32, ones, first, pulses);
    checkOutput("bp 0x22 ones", ones, 4);
    checkOutput("bp 0x22 underrun", pulses, 1);
    enable_i = 1'b0;
    step();
    enable_i = 1'b1;
    applyStimulus(3, ones, first, pulses);
    checkOutput("empty enable busy", int'(busy_o), 0);
    checkOutput("empty enable underrun", pulses, 0);
    enable_i = 1'b0;
    step();

    // Extremes back to back: residual accumulator carries into the 0xFF window.
    pushSample(8'h00);
    pushSample(8'hFF);
    enable_i = 1'b1;
    step();
    applyStimulus(32, ones, first, pulses);
    checkOutput("ext 0x00 ones", ones, 0);
    checkOutput("ext 0x00 underrun", pulses, 0);
    applyStimulus(32, ones, first, pulses);
    checkOutput("ext 0xFF ones", ones, 31);
    checkOutput("ext 0xFF underrun", pulses, 1);
    enable_i = 1'b0;
    step();

    // Underrun repeats the held sample every window.
    pushSample(8'h40);
    enable_i = 1'b1;
    step();
    applyStimulus(96, ones, first, pulses);
    checkOutput("repeat ones", ones, 24);
    checkOutput("repeat underruns", pulses, 3);
    enable_i = 1'b0;
    step();

    // Disable mid-sample, then resume with the next queued sample.
    pushSample(8'h80);
    pushSample(8'h40);
    checkOutput("dis full ready", int'(ready_o), 0);
    enable_i = 1'b1;
    step();
    checkOutput("dis ready after pop", int'(ready_o), 1);
    applyStimulus(10, ones, first, pulses);
    checkOutput("dis partial ones", ones, 5);
    enable_i = 1'b0;
    step();
    checkOutput("dis bit", int'(bit_o), 0);
    checkOutput("dis busy", int'(busy_o), 0);
    checkOutput("dis ready", int'(ready_o), 1);
    enable_i = 1'b1;
    step();
    checkOutput("resume busy", int'(busy_o), 1);
    applyStimulus(32, ones, first, pulses);
    checkOutput("resume ones", ones, 8);
    checkOutput("resume first4", int'(first), int'(4'b0001));
    checkOutput("resume underrun", pulses, 1);
    enable_i = 1'b0;
    step();

    // Asynchronous reset between edges flushes everything.
    pushSample(8'hFF);
    pushSample(8'h22);
    enable_i = 1'b1;
    step();
    applyStimulus(5, ones, first, pulses);
    checkOutput("pre-reset ones", ones, 4);
    checkOutput("pre-reset bit", int'(bit_o), 1);
    #2;
    rst_ni = 1'b0;
    #1;
    checkOutput("async bit", int'(bit_o), 0);
    checkOutput("async busy", int'(busy_o), 0);
    checkOutput("async ready", int'(ready_o), 1);
    checkOutput("async underrun", int'(underrun_o), 0);
    #2;
    rst_ni = 1'b1;
    applyStimulus(3, ones, first, pulses);
    checkOutput("post-reset flushed busy", int'(busy_o), 0);
    checkOutput("post-reset ones", ones, 0);
    enable_i = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
